// File: rtl/ahb_rd_arbiter.sv
// Two-requester read arbiter onto a single AHB-lite master port.
// One outstanding transfer; round-robin or fixed-priority selection by PRIO_MODE.
module ahb_rd_arbiter #(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic [31:0] r0_addr,
  output logic        r0_gnt,
  output logic [31:0] r0_rdata,
  output logic        r0_rvld,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic [31:0] r1_addr,
  output logic        r1_gnt,
  output logic [31:0] r1_rdata,
  output logic        r1_rvld,
  output logic        r1_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]    HSIZE_WORD    = 3'b010;
  localparam logic [AW-1:0] ADDR_MASK     = 32'hFFFF_FFFC;

  logic [1:0]    r_state;
  logic [AW-1:0] r_haddr;
  logic [1:0]    r_htrans;
  logic          r_owner;
  logic          r_last;
  logic [1:0]    r_gnt;
  logic [1:0]    r_rvld;
  logic [1:0]    r_err;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic [1:0]    w_state_nxt;
  logic [AW-1:0] w_haddr_nxt;
  logic [1:0]    w_htrans_nxt;
  logic          w_owner_nxt;
  logic          w_last_nxt;
  logic [1:0]    w_gnt_nxt;
  logic [1:0]    w_rvld_nxt;
  logic [1:0]    w_err_nxt;
  logic [DW-1:0] w_rdata0_nxt;
  logic [DW-1:0] w_rdata1_nxt;
  logic          w_win;
  logic [DW-1:0] w_cpl_data;

  // Winner selection: 0 = r0, 1 = r1; ties alternate away from the last grant
  always_comb begin
    w_win = 1'b0;
    if (PRIO_MODE != 0) begin
      w_win = ~r0_req;
    end else if (r0_req && r1_req) begin
      w_win = ~r_last;
    end else begin
      w_win = ~r0_req;
    end
  end

  assign w_cpl_data = HRESP ? '0 : HRDATA;

  always_comb begin
    w_state_nxt  = r_state;
    w_haddr_nxt  = r_haddr;
    w_htrans_nxt = HTRANS_IDLE;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_gnt_nxt    = '0;
    w_rvld_nxt   = '0;
    w_err_nxt    = r_err;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    case (r_state)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          w_state_nxt  = S_ADDR;
          w_haddr_nxt  = (w_win ? r1_addr : r0_addr) & ADDR_MASK;
          w_htrans_nxt = HTRANS_NONSEQ;
          w_owner_nxt  = w_win;
          w_last_nxt   = w_win;
          w_gnt_nxt    = w_win ? 2'b10 : 2'b01;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          w_state_nxt = S_DATA;
        end else begin
          w_htrans_nxt = HTRANS_NONSEQ;
        end
      end
      S_DATA: begin
        // Completion goes only to the owner; the other requester keeps its results
        if (HREADY) begin
          w_state_nxt = S_IDLE;
          if (r_owner) begin
            w_rvld_nxt   = 2'b10;
            w_err_nxt[1] = HRESP;
            w_rdata1_nxt = w_cpl_data;
          end else begin
            w_rvld_nxt   = 2'b01;
            w_err_nxt[0] = HRESP;
            w_rdata0_nxt = w_cpl_data;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_haddr  <= '0;
      r_htrans <= HTRANS_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_gnt    <= '0;
      r_rvld   <= '0;
      r_err    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_haddr  <= w_haddr_nxt;
      r_htrans <= w_htrans_nxt;
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvld   <= w_rvld_nxt;
      r_err    <= w_err_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
    end
  end

  assign HADDR    = r_haddr;
  assign HTRANS   = r_htrans;
  assign HSIZE    = HSIZE_WORD;
  assign r0_gnt   = r_gnt[0];
  assign r1_gnt   = r_gnt[1];
  assign r0_rvld  = r_rvld[0];
  assign r1_rvld  = r_rvld[1];
  assign r0_err   = r_err[0];
  assign r1_err   = r_err[1];
  assign r0_rdata = r_rdata0;
  assign r1_rdata = r_rdata1;

endmodule

// File: tb/tb_ahb_rd_arbiter.sv
// Bench for ahb_rd_arbiter: round-robin and fixed-priority instances share stimulus
// and are checked against a transaction-level model of grants, addresses and results.
module tb_ahb_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r1_req;
  logic [31:0] r0_addr, r1_addr;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  logic [1:0][1:0]       gnt;
  logic [1:0][1:0]       rvld;
  logic [1:0][1:0]       err;
  logic [1:0][1:0][31:0] rdata;
  logic [1:0][31:0]      haddr;
  logic [1:0][1:0]       htrans;
  logic [1:0][2:0]       hsize;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state, indexed by [mode] and [requester]
  int          last [2];
  logic [31:0] exp_haddr [2];
  logic [31:0] exp_rdata [2][2];
  logic        exp_err   [2][2];

  always #5 clk = ~clk;

  ahb_rd_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(gnt[0][0]), .r0_rdata(rdata[0][0]),
    .r0_rvld(rvld[0][0]), .r0_err(err[0][0]),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(gnt[0][1]), .r1_rdata(rdata[0][1]),
    .r1_rvld(rvld[0][1]), .r1_err(err[0][1]),
    .HADDR(haddr[0]), .HTRANS(htrans[0]), .HSIZE(hsize[0]),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  ahb_rd_arbiter #(.PRIO_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(gnt[1][0]), .r0_rdata(rdata[1][0]),
    .r0_rvld(rvld[1][0]), .r0_err(err[1][0]),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(gnt[1][1]), .r1_rdata(rdata[1][1]),
    .r1_rvld(rvld[1][1]), .r1_err(err[1][1]),
    .HADDR(haddr[1]), .HTRANS(htrans[1]), .HSIZE(hsize[1]),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      last[m]      = 1;
      exp_haddr[m] = 32'h0;
      for (int r = 0; r < 2; r++) begin
        exp_rdata[m][r] = 32'h0;
        exp_err[m][r]   = 1'b0;
      end
    end
  endtask

  task automatic chk_phase(input string ph, input int m, input logic [1:0] etr,
                           input logic [1:0] egnt, input logic [1:0] ervld);
    chk($sformatf("%s m%0d HTRANS", ph, m), 32'(htrans[m]), 32'(etr));
    chk($sformatf("%s m%0d HADDR", ph, m), haddr[m], exp_haddr[m]);
    chk($sformatf("%s m%0d gnt", ph, m), 32'(gnt[m]), 32'(egnt));
    chk($sformatf("%s m%0d rvld", ph, m), 32'(rvld[m]), 32'(ervld));
  endtask

  task automatic chk_results(input string ph, input int m);
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("%s m%0d r%0d rdata", ph, m, r), rdata[m][r], exp_rdata[m][r]);
      chk($sformatf("%s m%0d r%0d err", ph, m, r), 32'(err[m][r]), 32'(exp_err[m][r]));
    end
  endtask

  // One read transfer, entered and left on the negedge of an IDLE cycle
  task automatic xfer(input logic q0, input logic q1, input logic [31:0] a0,
                      input logic [31:0] a1, input int aw, input int dw,
                      input logic [31:0] d, input logic resp, input logic drop);
    int w [2];
    r0_req = q0; r1_req = q1; r0_addr = a0; r1_addr = a1;
    HREADY = 1'b1; HRESP = 1'b0;
    for (int m = 0; m < 2; m++) begin
      if (m == 1)          w[m] = q0 ? 0 : 1;
      else if (q0 && q1)   w[m] = (last[m] == 0) ? 1 : 0;
      else                 w[m] = q0 ? 0 : 1;
      last[m]      = w[m];
      exp_haddr[m] = ((w[m] == 0) ? a0 : a1) & 32'hFFFF_FFFC;
    end
    for (int k = 0; k <= aw; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++)
        chk_phase("addr", m, 2'b10, (k == 0) ? 2'(1 << w[m]) : 2'b00, 2'b00);
      if (k == 0) begin
        r0_addr = $urandom; r1_addr = $urandom;
        if (drop) begin r0_req = 1'b0; r1_req = 1'b0; end
      end
      HREADY = (k == aw);
    end
    for (int k = 0; k <= dw; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) chk_phase("data", m, 2'b00, 2'b00, 2'b00);
      HREADY = (k == dw);
      HRDATA = (k == dw) ? d : $urandom;
      HRESP  = (k == dw) ? resp : 1'b0;
    end
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      exp_rdata[m][w[m]] = resp ? 32'h0 : d;
      exp_err[m][w[m]]   = resp;
      chk_phase("done", m, 2'b00, 2'b00, 2'(1 << w[m]));
      chk_results("done", m);
    end
    HRESP = 1'b0;
  endtask

  task automatic idle(input int n);
    r0_req = 1'b0; r1_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) chk_phase("idle", m, 2'b00, 2'b00, 2'b00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic q0, q1;
    rst_n = 1'b0; r0_req = 1'b0; r1_req = 1'b0; r0_addr = '0; r1_addr = '0;
    HREADY = 1'b1; HRDATA = '0; HRESP = 1'b0;
    model_reset();
    #12;
    for (int m = 0; m < 2; m++) begin
      chk_phase("reset", m, 2'b00, 2'b00, 2'b00);
      chk_results("reset", m);
      chk($sformatf("reset m%0d HSIZE", m), 32'(hsize[m]), 32'h2);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters held high: RR alternates from r0, fixed priority keeps r0
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 0, $urandom, 1'b0, 1'b0);
    idle(2);

    // Single read with unaligned address
    xfer(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0);
    idle(1);

    // Wait states: 2 in address phase, 3 in data phase
    xfer(1'b0, 1'b1, 32'h0, 32'h0000_4446, 2, 3, 32'h1234_5678, 1'b0, 1'b0);

    // Error on r1, then a clean r1 read clears err
    xfer(1'b0, 1'b1, 32'h0, 32'h0000_8000, 0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    xfer(1'b0, 1'b1, 32'h0, 32'h0000_8004, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0);

    // Request dropped after grant still completes
    xfer(1'b1, 1'b1, 32'h0000_0101, 32'h0000_0202, 1, 0, 32'h5555_AAAA, 1'b0, 1'b1);
    idle(1);

    // Asynchronous reset during the data phase
    r0_req = 1'b1; r1_req = 1'b1; r0_addr = 32'h0000_0F00; r1_addr = 32'h0000_0E00;
    HREADY = 1'b1;
    @(negedge clk);
    @(negedge clk);
    HRDATA = 32'h7777_7777;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk_phase("rst_data", m, 2'b00, 2'b00, 2'b00);
      chk_results("rst_data", m);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) chk_phase("rst_hold", m, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    idle(2);
    xfer(1'b1, 1'b1, 32'h0000_0A0A, 32'h0000_0B0B, 0, 0, 32'hFEED_FACE, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      q0 = 1'($urandom_range(0, 1));
      q1 = 1'($urandom_range(0, 1));
      if (!q0 && !q1) q1 = 1'b1;
      xfer(q0, q1, $urandom, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
           $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
